// File: rtl/change_dispenser_pkg.sv
// Shared note-denomination definitions for the change dispenser and the vending controller.
// The value table is ordered from largest to smallest note; the index order matches refill_sel and eject.
package change_dispenser_pkg;

  localparam int NUM_DENOM = 5;
  localparam int IDX_W     = 3;

  localparam logic [IDX_W-1:0] D_100 = 3'd0;
  localparam logic [IDX_W-1:0] D_50  = 3'd1;
  localparam logic [IDX_W-1:0] D_20  = 3'd2;
  localparam logic [IDX_W-1:0] D_10  = 3'd3;
  localparam logic [IDX_W-1:0] D_5   = 3'd4;

  localparam int unsigned DENOM_VALUE [NUM_DENOM] = '{100, 50, 20, 10, 5};

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_PLAN     = 3'd1;
  localparam state_t ST_EJECT    = 3'd2;
  localparam state_t ST_WAIT_ACK = 3'd3;
  localparam state_t ST_DONE     = 3'd4;

  function automatic int unsigned denom_value(input logic [IDX_W-1:0] idx);
    case (idx)
      D_100:   denom_value = 100;
      D_50:    denom_value = 50;
      D_20:    denom_value = 20;
      D_10:    denom_value = 10;
      D_5:     denom_value = 5;
      default: denom_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_note_inventory.sv
// Per-denomination note counters: saturating refill, and decrement that stops at zero.
module note_inventory
  import change_dispenser_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 refill_valid,
  input  logic [IDX_W-1:0]                     refill_sel,
  input  logic [CNT_W-1:0]                     refill_count,
  input  logic                                 dec_valid,
  input  logic [IDX_W-1:0]                     dec_sel,
  output logic [NUM_DENOM-1:0][CNT_W-1:0]      inv
);

  generate
    for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W:0]   sum;

      // Extra carry bit tells us when the refill would wrap.
      assign sum     = {1'b0, cnt_reg} + {1'b0, refill_count};
      assign inv[gi] = cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (refill_valid && refill_sel == IDX_W'(gi)) begin
          cnt_reg <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end else if (dec_valid && dec_sel == IDX_W'(gi) && cnt_reg != '0) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: plans a greedy note breakdown against inventory, then ejects notes
// one at a time with per-note acknowledge and timeout, reporting paid amount and shortfall.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMOUNT_W    = 10,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [AMOUNT_W-1:0]   req_amount,
  output logic                  req_ready,
  input  logic                  refill_valid,
  input  logic [IDX_W-1:0]      refill_sel,
  input  logic [CNT_W-1:0]      refill_count,
  output logic [NUM_DENOM-1:0]  eject,
  input  logic                  eject_ack,
  output logic                  busy,
  output logic                  done,
  output logic [AMOUNT_W-1:0]   paid_out,
  output logic [AMOUNT_W-1:0]   shortfall,
  output logic                  fault
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  state_t                          state_reg;
  logic [IDX_W-1:0]                d_reg;
  logic [AMOUNT_W-1:0]             amount_reg;
  logic [AMOUNT_W-1:0]             remaining_reg;
  logic [AMOUNT_W-1:0]             paid_reg;
  logic [AMOUNT_W-1:0]             short_reg;
  logic                            fault_reg;
  logic [TMR_W-1:0]                timer_reg;
  logic [NUM_DENOM-1:0][CNT_W-1:0] plan_reg;
  logic [NUM_DENOM-1:0][CNT_W-1:0] inv;

  logic [AMOUNT_W-1:0]             quot [NUM_DENOM];
  logic [CNT_W-1:0]                plan_next;
  logic [AMOUNT_W-1:0]             deduct;
  logic [AMOUNT_W-1:0]             cur_value;
  logic [CNT_W-1:0]                cur_plan;
  logic                            last_d;
  logic                            timed_out;
  logic                            ack_take;
  logic                            refill_take;

  // Constant divisors per denomination; the active one is muxed by d_reg.
  generate
    for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_quot
      assign quot[gi] = remaining_reg / AMOUNT_W'(DENOM_VALUE[gi]);
    end
  endgenerate

  always_comb begin
    plan_next = inv[d_reg];
    if ({{CNT_W{1'b0}}, quot[d_reg]} < {{AMOUNT_W{1'b0}}, inv[d_reg]}) begin
      plan_next = CNT_W'(quot[d_reg]);
    end
  end

  assign cur_value   = AMOUNT_W'(denom_value(d_reg));
  assign deduct      = AMOUNT_W'(32'(plan_next) * 32'(cur_value));
  assign cur_plan    = plan_reg[d_reg];
  assign last_d      = (d_reg == D_5);
  assign timed_out   = (timer_reg == TMR_W'(ACK_TIMEOUT));
  assign ack_take    = (state_reg == ST_WAIT_ACK) && eject_ack && !timed_out;
  assign refill_take = (state_reg == ST_IDLE) && refill_valid;

  note_inventory #(.CNT_W(CNT_W)) u_inv (
    .clk          (clk),
    .rst          (rst),
    .refill_valid (refill_take),
    .refill_sel   (refill_sel),
    .refill_count (refill_count),
    .dec_valid    (ack_take),
    .dec_sel      (d_reg),
    .inv          (inv)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      d_reg         <= '0;
      amount_reg    <= '0;
      remaining_reg <= '0;
      paid_reg      <= '0;
      short_reg     <= '0;
      fault_reg     <= 1'b0;
      timer_reg     <= '0;
      plan_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            amount_reg    <= req_amount;
            remaining_reg <= req_amount;
            paid_reg      <= '0;
            short_reg     <= '0;
            d_reg         <= '0;
            state_reg     <= ST_PLAN;
          end
        end
        ST_PLAN: begin
          plan_reg[d_reg] <= plan_next;
          remaining_reg   <= remaining_reg - deduct;
          if (last_d) begin
            d_reg     <= '0;
            state_reg <= ST_EJECT;
          end else begin
            d_reg <= d_reg + 1'b1;
          end
        end
        ST_EJECT: begin
          if (cur_plan != '0) begin
            timer_reg <= '0;
            state_reg <= ST_WAIT_ACK;
          end else if (last_d) begin
            short_reg <= amount_reg - paid_reg;
            state_reg <= ST_DONE;
          end else begin
            d_reg <= d_reg + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          // Timeout wins over a late ack on the same cycle; unpaid plan is abandoned.
          if (timed_out) begin
            fault_reg <= 1'b1;
            short_reg <= amount_reg - paid_reg;
            state_reg <= ST_DONE;
          end else if (eject_ack) begin
            plan_reg[d_reg] <= cur_plan - 1'b1;
            paid_reg        <= paid_reg + cur_value;
            state_reg       <= ST_EJECT;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign eject     = (state_reg == ST_EJECT && cur_plan != '0) ?
                     (NUM_DENOM'(1) << d_reg) : '0;
  assign paid_out  = paid_reg;
  assign shortfall = short_reg;
  assign fault     = fault_reg;

endmodule
